memory_scan_ctrl: RTL and testbench
===================================

# memory_scan_ctrl

Sequencer that drives the memory bank scan chain (15 data cells, button cell, LED cell, 16-bit locking key; 144 bits total) from a byte-wide load/readback stream. Sits between the external programming port and the memory bank. Owns `scan_enable`/`scan_in`, samples `scan_out`, and holds the CPU off the bank while a transfer is in progress. Supports full-chain load (new image in, old image out) and non-destructive dump (chain rotated back into itself).

## Interface
Parameters:
- `CHAIN_LEN`, 144: total scan chain bits; must be a multiple of 8.
- `BYTE_W`, 8: stream width.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request to begin a transfer; sampled only in IDLE.
- `mode`  in  1  sampled with `start`: 0 = LOAD, 1 = DUMP (rotate).
- `abort`  in  1  terminate the current transfer.
- `in_data`  in  8  load byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  controller accepts `in_data` this cycle.
- `out_data`  out  8  byte captured from `scan_out`.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  consumer accepts `out_data`.
- `scan_enable`  out  1  to memory bank.
- `scan_in`  out  1  to memory bank chain head.
- `scan_out`  in  1  from memory bank chain tail.
- `cpu_hold`  out  1  stall CPU / block bank writes.
- `busy`  out  1  not in IDLE.
- `done`  out  1  one-cycle pulse on normal completion.
- `aborted`  out  1  one-cycle pulse on abort.

## Operation
- States: IDLE, FETCH, SHIFT, EMIT, FINISH.
- IDLE: `start`=1 latches `mode` and clears the byte counter. Next state is FETCH (LOAD) or SHIFT (DUMP).
- FETCH (LOAD only): `in_ready`=1. An `in_valid` && `in_ready` handshake loads the tx byte; next state is SHIFT.
- SHIFT: exactly 8 cycles with `scan_enable`=1, one bit per cycle, LSB first.
  - LOAD: `scan_in` = tx bit.
  - DUMP: `scan_in` = `scan_out` (rotate).
  - `scan_out` is sampled in the same cycle, before the edge, into rx bit (first bit to rx[0]). Next state is EMIT.
- EMIT: `out_valid`=1 with `out_data`=rx byte. On `out_ready`, increment the byte counter. If counter = `CHAIN_LEN/8`, go to FINISH; else go to FETCH (LOAD) or SHIFT (DUMP).
- FINISH: `done`=1 for one cycle, then IDLE.
- `scan_enable` is 0 in every state except SHIFT. The chain holds during FETCH and EMIT stalls, so backpressure never corrupts data.
- `cpu_hold` = `busy`, asserted from the cycle after `start` through FINISH inclusive.
- `abort` in any non-IDLE state: next state IDLE, `aborted`=1 for one cycle, no `done`. Chain contents are the partially shifted image; no recovery is attempted.
- Simultaneous events:
  - `abort` with `start` in IDLE: `start` wins; `abort` is ignored in IDLE.
  - `abort` during an EMIT handshake: the byte is consumed and the transfer is aborted.
  - `start` while busy: ignored.
- Byte counter width is `$clog2(CHAIN_LEN/8+1)`. Bit counter is 3 bits and wraps 7→0 on SHIFT exit.

## Timing
- Reset (`rst`=0): state IDLE. All outputs 0: `in_ready`, `out_valid`, `out_data`=0x00, `scan_enable`, `scan_in`, `cpu_hold`, `busy`, `done`, `aborted`. Counters cleared.
- Reset mid-transfer takes effect immediately (asynchronous): `scan_enable` drops without waiting for a clock edge.
- All outputs are registered or decoded from state only. There is no combinational path from `in_valid`/`out_ready` to any output.
- DUMP, no stalls: each byte costs 8 SHIFT cycles + 1 EMIT cycle. A full transfer is 18×9 + 1 (FINISH) = 163 cycles from `start` edge to `done`.
- LOAD, no stalls: each byte costs 1 FETCH + 8 SHIFT + 1 EMIT. A full transfer is 18×10 + 1 = 181 cycles.
- The first `out_valid` is asserted 9 cycles (DUMP) or 10 cycles (LOAD, `in_valid` held high) after `start`.

## Structure
- Package `memory_scan_pkg` holds:
  - State enum.
  - `SCAN_CHAIN_LEN` = 144, derived as 15×8 + 1 + 7 + 16.
  - `SCAN_BYTES` = 18.
- One sub-module, `scan_serdes`: 8-bit tx shift register plus rx shift register with `load`, `shift` and `bit_cnt`. The FSM and byte counter stay in the top level.

## Test plan
- LOAD 18 bytes 0x00..0x11 into a reset bank, then DUMP → the 18 output bytes of the DUMP read 0x00..0x11, and cell 0 of the bank reads 0x00.
- DUMP twice in succession → both byte streams are identical and bank contents are unchanged; `done` pulses once per transfer.
- LOAD with `in_valid` gapped 3 cycles per byte and `out_ready` low 5 cycles per byte → `scan_enable` stays 0 during every stall; final contents are correct.
- LOAD with the locking key bytes set to 0xA5, 0x5A → the `locking_key` output of the bank equals 0x5AA5 after `done`.
- `abort` asserted at byte 7, mid-SHIFT → `aborted` pulses, `busy`/`cpu_hold` fall the next cycle, and no `done` is seen. Then `rst`=0 asynchronously mid-SHIFT → all outputs are 0 immediately.
- `start` pulsed while busy, and `start`+`abort` in IDLE → the second `start` is ignored; the transfer starts and no `aborted` pulse occurs.

Source files
------------

// File: rtl/memory_scan_pkg.sv
// memory_scan_pkg: shared state type and scan chain geometry for the
// memory bank scan sequencer.
package memory_scan_pkg;

   // Sequencer states; fixed encoding keeps waveforms readable across builds.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_SHIFT  = 3'd2,
      ST_EMIT   = 3'd3,
      ST_FINISH = 3'd4
   } scan_state_t;

   // Chain composition, head to tail: 15 byte-wide data cells, button cell,
   // LED cell and the 16-bit locking key.
   localparam int SCAN_DATA_CELLS  = 32'sd15;
   localparam int SCAN_CELL_BITS   = 32'sd8;
   localparam int SCAN_BUTTON_BITS = 32'sd1;
   localparam int SCAN_LED_BITS    = 32'sd7;
   localparam int SCAN_KEY_BITS    = 32'sd16;

   localparam int SCAN_CHAIN_LEN = SCAN_DATA_CELLS * SCAN_CELL_BITS
                                 + SCAN_BUTTON_BITS + SCAN_LED_BITS
                                 + SCAN_KEY_BITS;
   localparam int SCAN_BYTES     = SCAN_CHAIN_LEN / 32'sd8;

   // Number of stream bytes needed to cover a chain of the given length.
   function automatic int chain_bytes(input int chain_len, input int byte_w);
      return chain_len / byte_w;
   endfunction

endpackage

// File: rtl/scan_serdes.sv
// scan_serdes: byte-to-bit serializer for the scan chain head and
// bit-to-byte deserializer for the chain tail. Bits move LSB first; the
// first bit captured ends up in rx_data[0] after W shifts.
module scan_serdes #(
   parameter int W  = 8,
   parameter int CW = $clog2(W)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] load_data,
   input  logic         ser_in,
   output logic         tx_bit,
   output logic [W-1:0] rx_data,
   output logic         last_bit
);

   logic [W-1:0]  tx_r;
   logic [W-1:0]  rx_r;
   logic [CW-1:0] bit_cnt_r;

   // Transmit register: parallel load from the stream, shift right toward the chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_r <= {W{1'b0}};
      end else if (load) begin
         tx_r <= load_data;
      end else if (shift) begin
         tx_r <= {1'b0, tx_r[W-1:1]};
      end
   end

   // Receive register: chain tail enters at the MSB so the first bit lands in bit 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_r <= {W{1'b0}};
      end else if (shift) begin
         rx_r <= {ser_in, rx_r[W-1:1]};
      end
   end

   // Bit position within the current byte; wraps to zero on the last shift.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_r <= {CW{1'b0}};
      end else if (clr) begin
         bit_cnt_r <= {CW{1'b0}};
      end else if (shift) begin
         bit_cnt_r <= bit_cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
   end

   assign tx_bit   = tx_r[0];
   assign rx_data  = rx_r;
   assign last_bit = (bit_cnt_r == CW'(W - 1));

endmodule

// File: rtl/memory_scan_ctrl.sv
// memory_scan_ctrl: sequences byte-wide load/readback of the memory bank scan
// chain. LOAD shifts a new image in while capturing the old one; DUMP rotates
// the chain through itself so the bank contents survive a readback. The chain
// only moves in SHIFT, so stream backpressure can never corrupt it.
module memory_scan_ctrl
   import memory_scan_pkg::*;
#(
   parameter int CHAIN_LEN = SCAN_CHAIN_LEN,
   parameter int BYTE_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic              abort,
   input  logic [BYTE_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [BYTE_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              scan_enable,
   output logic              scan_in,
   input  logic              scan_out,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              aborted
);

   localparam int NBYTES = chain_bytes(CHAIN_LEN, BYTE_W);
   localparam int CNT_W  = $clog2(NBYTES + 1);

   scan_state_t      state_r;
   scan_state_t      state_s;
   logic             mode_r;
   logic             mode_s;
   logic [CNT_W-1:0] byte_cnt_r;
   logic [CNT_W-1:0] byte_cnt_s;
   logic             aborted_r;
   logic             aborted_s;
   logic             clr_s;
   logic             load_s;
   logic             shift_s;
   logic             tx_bit_s;
   logic             last_bit_s;
   logic             in_shift_s;

   // State, latched mode, byte counter and abort pulse registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= ST_IDLE;
         mode_r     <= 1'b0;
         byte_cnt_r <= {CNT_W{1'b0}};
         aborted_r  <= 1'b0;
      end else begin
         state_r    <= state_s;
         mode_r     <= mode_s;
         byte_cnt_r <= byte_cnt_s;
         aborted_r  <= aborted_s;
      end
   end

   // Next-state, counter and serdes control decode.
   always_comb begin
      state_s    = state_r;
      mode_s     = mode_r;
      byte_cnt_s = byte_cnt_r;
      aborted_s  = 1'b0;
      clr_s      = 1'b0;
      load_s     = 1'b0;
      shift_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            // abort is meaningless here, so start always wins
            if (start) begin
               mode_s     = mode;
               byte_cnt_s = {CNT_W{1'b0}};
               clr_s      = 1'b1;
               state_s    = mode ? ST_SHIFT : ST_FETCH;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (abort) begin
               aborted_s = 1'b1;
               state_s   = ST_IDLE;
            end else if (in_valid) begin
               load_s  = 1'b1;
               state_s = ST_SHIFT;
            end else begin
               state_s = ST_FETCH;
            end
         end
         ST_SHIFT: begin
            // the bank shifts whenever scan_enable is high, so the serdes
            // follows it even in an aborting cycle
            shift_s = 1'b1;
            if (abort) begin
               aborted_s = 1'b1;
               state_s   = ST_IDLE;
            end else if (last_bit_s) begin
               state_s = ST_EMIT;
            end else begin
               state_s = ST_SHIFT;
            end
         end
         ST_EMIT: begin
            // a byte taken in the same cycle as abort still counts as consumed
            if (out_ready) begin
               byte_cnt_s = byte_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
               byte_cnt_s = byte_cnt_r;
            end
            if (abort) begin
               aborted_s = 1'b1;
               state_s   = ST_IDLE;
            end else if (out_ready) begin
               if (byte_cnt_s == CNT_W'(NBYTES)) begin
                  state_s = ST_FINISH;
               end else begin
                  state_s = mode_r ? ST_SHIFT : ST_FETCH;
               end
            end else begin
               state_s = ST_EMIT;
            end
         end
         ST_FINISH: begin
            // transfer is already complete; done is on the wire this cycle
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   scan_serdes #(
      .W (BYTE_W)
   ) u_serdes (
      .clk       (clk),
      .rst_n     (rst),
      .clr       (clr_s),
      .load      (load_s),
      .shift     (shift_s),
      .load_data (in_data),
      .ser_in    (scan_out),
      .tx_bit    (tx_bit_s),
      .rx_data   (out_data),
      .last_bit  (last_bit_s)
   );

   // Outputs are pure state decodes so reset drops them without a clock edge.
   assign in_shift_s  = (state_r == ST_SHIFT);
   assign in_ready    = (state_r == ST_FETCH);
   assign out_valid   = (state_r == ST_EMIT);
   assign scan_enable = in_shift_s;
   assign scan_in     = in_shift_s & (mode_r ? scan_out : tx_bit_s);
   assign busy        = (state_r != ST_IDLE);
   assign cpu_hold    = busy;
   assign done        = (state_r == ST_FINISH);
   assign aborted     = aborted_r;

endmodule

// File: tb/tb_memory_scan_ctrl.sv
// tb_memory_scan_ctrl: drives memory_scan_ctrl against a bit-level bank chain
// fixture and a byte-image reference model of the bank contents.
module tb_memory_scan_ctrl;

   localparam int NB = 18;
   localparam int CL = 144;

   logic       clk = 1'b0;
   logic       rst, start, mode, abort;
   logic [7:0] in_data, out_data;
   logic       in_valid, in_ready, out_valid, out_ready;
   logic       scan_enable, scan_in, scan_out;
   logic       cpu_hold, busy, done, aborted;
   logic [CL-1:0] chain = '0;

   int checks   = 0;
   int failures = 0;

   // reference model: bank image as bytes in stream order, plus load data
   logic [7:0] image    [NB];
   logic [7:0] tx_bytes [NB];

   // per-transfer observations
   int r_done_cyc, r_first_ov, r_n_done, r_n_abort, r_stall_bad, r_hold_bad;
   int r_aborted_cyc, r_n_out, r_busy_after, r_busy_abort;

   typedef struct {
      bit md;
      int gin;
      int gout;
      int pat;
      int exp_cyc;
      int exp_first;
   } vec_t;
   vec_t tbl [8];

   always #5 clk = ~clk;

   memory_scan_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .mode        (mode),
      .abort       (abort),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .scan_enable (scan_enable),
      .scan_in     (scan_in),
      .scan_out    (scan_out),
      .cpu_hold    (cpu_hold),
      .busy        (busy),
      .done        (done),
      .aborted     (aborted)
   );

   // bank scan chain: head enters at the top bit, tail leaves from bit 0
   assign scan_out = chain[0];
   always @(posedge clk) begin
      if (scan_enable) chain <= {scan_in, chain[CL-1:1]};
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic fill_tx(input int pat);
      for (int i = 0; i < NB; i++) begin
         if (pat == 0) tx_bytes[i] = 8'(i);
         else          tx_bytes[i] = 8'($urandom_range(0, 255));
      end
      if (pat == 2) begin
         tx_bytes[16] = 8'hA5;
         tx_bytes[17] = 8'h5A;
      end
   endtask

   task automatic check_bank();
      for (int i = 0; i < NB; i++)
         check($sformatf("bank[%0d]", i), 32'(chain[8*i +: 8]), 32'(image[i]));
   endtask

   task automatic run_xfer(input bit md, input int gin, input int gout, input bit chk_out,
                           input int restart_cyc, input bit abort_with_start, input int abort_cyc);
      logic [7:0] exp_img [NB];
      int in_idx, in_wait, out_wait, cyc;
      bit fin;
      for (int i = 0; i < NB; i++) exp_img[i] = image[i];
      in_idx = 0; in_wait = 0; out_wait = 0; fin = 1'b0;
      r_done_cyc = -1; r_first_ov = -1; r_n_done = 0; r_n_abort = 0;
      r_stall_bad = 0; r_hold_bad = 0; r_aborted_cyc = -1; r_n_out = 0;
      r_busy_after = -1; r_busy_abort = -1;
      @(negedge clk);
      start = 1'b1; mode = md; abort = abort_with_start;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      cyc = 1;
      while (!fin) begin
         if (busy !== cpu_hold) r_hold_bad++;
         if (scan_enable && (in_ready || out_valid)) r_stall_bad++;
         if (out_valid === 1'b1 && r_first_ov < 0) r_first_ov = cyc;
         if (done === 1'b1) begin
            r_n_done++;
            if (r_done_cyc < 0) r_done_cyc = cyc;
         end
         if (aborted === 1'b1) begin
            r_n_abort++;
            if (r_aborted_cyc < 0) begin
               r_aborted_cyc = cyc;
               r_busy_abort  = int'(busy | cpu_hold);
            end
         end
         if (r_done_cyc >= 0 && cyc > r_done_cyc) begin
            r_busy_after = int'(busy | cpu_hold);
            fin = 1'b1;
         end else if (abort_cyc >= 0 && cyc > abort_cyc + 4) begin
            fin = 1'b1;
         end else if (cyc >= 2000) begin
            fin = 1'b1;
         end
         start = (cyc == restart_cyc);
         mode  = (cyc == restart_cyc) ? ~md : md;
         abort = (cyc == abort_cyc);
         if (in_ready === 1'b1) begin
            if (in_wait >= gin && in_idx < NB) begin
               in_valid = 1'b1;
               in_data  = tx_bytes[in_idx];
               in_idx++;
            end else begin
               in_valid = 1'b0;
            end
            in_wait++;
         end else begin
            in_valid = 1'b0;
            in_wait  = 0;
         end
         if (out_valid === 1'b1) begin
            if (out_wait >= gout) begin
               out_ready = 1'b1;
               if (chk_out && r_n_out < NB)
                  check($sformatf("dout[%0d]", r_n_out), 32'(out_data), 32'(exp_img[r_n_out]));
               r_n_out++;
            end else begin
               out_ready = 1'b0;
            end
            out_wait++;
         end else begin
            out_ready = 1'b0;
            out_wait  = 0;
         end
         if (!fin) begin
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
   endtask

   // common checks for a transfer that must complete normally
   task automatic check_complete(input string tag, input int exp_cyc, input int exp_first);
      check({tag, ".done_cyc"},  32'(r_done_cyc),   32'(exp_cyc));
      check({tag, ".first_ov"},  32'(r_first_ov),   32'(exp_first));
      check({tag, ".n_done"},    32'(r_n_done),     32'd1);
      check({tag, ".n_abort"},   32'(r_n_abort),    32'd0);
      check({tag, ".n_out"},     32'(r_n_out),      32'(NB));
      check({tag, ".stall_se"},  32'(r_stall_bad),  32'd0);
      check({tag, ".hold_busy"}, 32'(r_hold_bad),   32'd0);
      check({tag, ".busy_end"},  32'(r_busy_after), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit md;
      int gin, gout, ec, ef;
      rst = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0;
      in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
      for (int i = 0; i < NB; i++) image[i] = 8'h00;

      tbl[0] = '{1'b0, 0, 0, 0, 181, 10};
      tbl[1] = '{1'b1, 0, 0, 0, 163, 9};
      tbl[2] = '{1'b1, 0, 0, 0, 163, 9};
      tbl[3] = '{1'b0, 3, 5, 1, 325, 13};
      tbl[4] = '{1'b1, 0, 2, 0, 199, 9};
      tbl[5] = '{1'b0, 0, 0, 2, 181, 10};
      tbl[6] = '{1'b1, 1, 0, 0, 163, 9};
      tbl[7] = '{1'b0, 2, 0, 1, 217, 12};

      repeat (2) @(negedge clk);
      check("rst.outs", 32'({in_ready, out_valid, scan_enable, scan_in, cpu_hold, busy, done, aborted}), 32'd0);
      check("rst.out_data", 32'(out_data), 32'h00);
      rst = 1'b1;

      for (int v = 0; v < 8; v++) begin
         if (!tbl[v].md) fill_tx(tbl[v].pat);
         run_xfer(tbl[v].md, tbl[v].gin, tbl[v].gout, 1'b1, -1, 1'b0, -1);
         check_complete($sformatf("vec%0d", v), tbl[v].exp_cyc, tbl[v].exp_first);
         if (!tbl[v].md) for (int i = 0; i < NB; i++) image[i] = tx_bytes[i];
         check_bank();
         if (v == 1) check("vec1.cell0", 32'(chain[7:0]), 32'h00);
         if (v == 5) check("vec5.key", 32'(chain[143:128]), 32'h5AA5);
      end

      for (int r = 0; r < 6; r++) begin
         md   = 1'($urandom_range(0, 1));
         gin  = $urandom_range(0, 3);
         gout = $urandom_range(0, 3);
         if (!md) fill_tx(1);
         ec = NB * ((md ? 0 : 1 + gin) + 8 + 1 + gout) + 1;
         ef = md ? 9 : 10 + gin;
         run_xfer(md, gin, gout, 1'b1, -1, 1'b0, -1);
         check_complete($sformatf("rnd%0d", r), ec, ef);
         if (!md) for (int i = 0; i < NB; i++) image[i] = tx_bytes[i];
         check_bank();
      end

      // start pulsed while busy (with the other mode) is ignored
      run_xfer(1'b1, 0, 0, 1'b1, 5, 1'b0, -1);
      check_complete("restart", 163, 9);
      check_bank();

      // start together with abort in IDLE: start wins, no aborted pulse
      run_xfer(1'b1, 0, 0, 1'b1, -1, 1'b1, -1);
      check_complete("start_abort", 163, 9);
      check_bank();

      // abort at byte 7, mid-SHIFT
      run_xfer(1'b1, 0, 0, 1'b1, -1, 1'b0, 7 * 9 + 4);
      check("abort.cyc",     32'(r_aborted_cyc), 32'(7 * 9 + 5));
      check("abort.n_abort", 32'(r_n_abort),     32'd1);
      check("abort.busy",    32'(r_busy_abort),  32'd0);
      check("abort.n_done",  32'(r_n_done),      32'd0);
      check("abort.n_out",   32'(r_n_out),       32'd7);

      // asynchronous reset mid-SHIFT
      @(negedge clk);
      start = 1'b1; mode = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("arst.pre_se", 32'(scan_enable), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("arst.outs", 32'({in_ready, out_valid, scan_enable, scan_in, cpu_hold, busy, done, aborted}), 32'd0);
      check("arst.out_data", 32'(out_data), 32'h00);
      @(negedge clk);
      rst = 1'b1;

      // recover a known image, then read it back
      fill_tx(1);
      run_xfer(1'b0, 0, 0, 1'b0, -1, 1'b0, -1);
      check_complete("reload", 181, 10);
      for (int i = 0; i < NB; i++) image[i] = tx_bytes[i];
      check_bank();
      run_xfer(1'b1, 0, 0, 1'b1, -1, 1'b0, -1);
      check_complete("redump", 163, 9);
      check_bank();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
